// File: rtl/fft_frame_sequencer_if.sv
// Signal bundle between the frame sequencer and its neighbours: synth sample
// stream, FFT core Avalon-ST sink/source, spectral bin stream and status.
interface fft_frame_sequencer_if;
  logic        enable;
  logic        smp_valid;
  logic        smp_ready;
  logic [23:0] smp_data;
  logic        fft_sink_valid;
  logic        fft_sink_ready;
  logic        fft_sink_sop;
  logic        fft_sink_eop;
  logic [23:0] fft_sink_real;
  logic [23:0] fft_sink_imag;
  logic [1:0]  fft_sink_error;
  logic [8:0]  fft_fftpts_in;
  logic        fft_inverse;
  logic        fft_source_valid;
  logic        fft_source_ready;
  logic        fft_source_sop;
  logic        fft_source_eop;
  logic [1:0]  fft_source_error;
  logic [23:0] fft_source_real;
  logic [23:0] fft_source_imag;
  logic        bin_valid;
  logic        bin_ready;
  logic [23:0] bin_real;
  logic [23:0] bin_imag;
  logic [7:0]  bin_index;
  logic        bin_last;
  logic        busy;
  logic        frame_err;
  logic [15:0] frame_count;

  modport master (
    input  enable, smp_valid, smp_data, fft_sink_ready,
           fft_source_valid, fft_source_sop, fft_source_eop, fft_source_error,
           fft_source_real, fft_source_imag, bin_ready,
    output smp_ready, fft_sink_valid, fft_sink_sop, fft_sink_eop, fft_sink_real,
           fft_sink_imag, fft_sink_error, fft_fftpts_in, fft_inverse,
           fft_source_ready, bin_valid, bin_real, bin_imag, bin_index, bin_last,
           busy, frame_err, frame_count
  );

  modport slave (
    output enable, smp_valid, smp_data, fft_sink_ready,
           fft_source_valid, fft_source_sop, fft_source_eop, fft_source_error,
           fft_source_real, fft_source_imag, bin_ready,
    input  smp_ready, fft_sink_valid, fft_sink_sop, fft_sink_eop, fft_sink_real,
           fft_sink_imag, fft_sink_error, fft_fftpts_in, fft_inverse,
           fft_source_ready, bin_valid, bin_real, bin_imag, bin_index, bin_last,
           busy, frame_err, frame_count
  );
endinterface

// File: rtl/fft_frame_sequencer.sv
// Runs a streaming FFT core one frame at a time: frames samples into the core,
// forwards indexed bins downstream, and recovers from core faults and stalls.
//
//   state | meaning
//   IDLE  | waiting for enable; counters cleared
//   FILL  | passing PTS samples into the core sink with sop/eop
//   WAIT  | frame sent, no bin yet; timeout running
//   DRAIN | passing bins from the core source downstream
//   FLUSH | discarding core output up to its eop after a fault
module fft_frame_sequencer #(
  parameter int PTS     = 256,
  parameter int TIMEOUT = 4096
) (
  input  logic                  clk,
  input  logic                  reset,
  fft_frame_sequencer_if.master bus
);

  localparam logic [7:0]  LAST     = 8'(PTS - 1);
  localparam logic [12:0] TMO_LAST = 13'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, FILL, WAIT, DRAIN, FLUSH} state_t;

  state_t      state_q, state_d;
  logic [7:0]  in_cnt_q, in_cnt_d;
  logic [7:0]  out_cnt_q, out_cnt_d;
  logic [12:0] tmo_q, tmo_d;
  logic [15:0] frame_count_q, frame_count_d;
  logic        frame_err_q, frame_err_d;
  logic        beat_fault;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      in_cnt_q      <= 8'd0;
      out_cnt_q     <= 8'd0;
      tmo_q         <= 13'd0;
      frame_count_q <= 16'd0;
      frame_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      in_cnt_q      <= in_cnt_d;
      out_cnt_q     <= out_cnt_d;
      tmo_q         <= tmo_d;
      frame_count_q <= frame_count_d;
      frame_err_q   <= frame_err_d;
    end
  end

  // A beat is faulty when its markers disagree with its position in the frame.
  assign beat_fault = (bus.fft_source_error != 2'b00)
                    | (bus.fft_source_sop != (out_cnt_q == 8'd0))
                    | (bus.fft_source_eop != (out_cnt_q == LAST));

  always_comb begin
    state_d              = state_q;
    in_cnt_d             = in_cnt_q;
    out_cnt_d            = out_cnt_q;
    tmo_d                = tmo_q;
    frame_count_d        = frame_count_q;
    frame_err_d          = 1'b0;
    bus.smp_ready        = 1'b0;
    bus.fft_sink_valid   = 1'b0;
    bus.fft_sink_sop     = 1'b0;
    bus.fft_sink_eop     = 1'b0;
    bus.fft_source_ready = 1'b0;
    bus.bin_valid        = 1'b0;
    bus.bin_last         = 1'b0;

    case (state_q)
      IDLE: begin
        in_cnt_d  = 8'd0;
        out_cnt_d = 8'd0;
        tmo_d     = 13'd0;
        if (bus.enable) state_d = FILL;
      end

      FILL: begin
        bus.smp_ready      = bus.fft_sink_ready;
        bus.fft_sink_valid = bus.smp_valid;
        bus.fft_sink_sop   = (in_cnt_q == 8'd0);
        bus.fft_sink_eop   = (in_cnt_q == LAST);
        out_cnt_d          = 8'd0;
        if (bus.smp_valid && bus.fft_sink_ready) begin
          if (in_cnt_q == LAST) begin
            in_cnt_d = 8'd0;
            tmo_d    = 13'd0;
            state_d  = WAIT;
          end else begin
            in_cnt_d = in_cnt_q + 8'd1;
          end
        end
      end

      WAIT, DRAIN: begin
        bus.fft_source_ready = bus.bin_ready;
        bus.bin_valid        = bus.fft_source_valid;
        bus.bin_last         = (out_cnt_q == LAST);
        if (bus.fft_source_valid && bus.bin_ready) begin
          tmo_d = 13'd0;
          if (beat_fault) begin
            frame_err_d = 1'b1;
            state_d     = bus.fft_source_eop ? IDLE : FLUSH;
          end else if (bus.fft_source_eop) begin
            frame_count_d = frame_count_q + 16'd1;
            out_cnt_d     = 8'd0;
            state_d       = bus.enable ? FILL : IDLE;
          end else begin
            out_cnt_d = out_cnt_q + 8'd1;
            state_d   = DRAIN;
          end
        end else if (state_q == WAIT) begin
          if (tmo_q == TMO_LAST) begin
            frame_err_d = 1'b1;
            tmo_d       = 13'd0;
            state_d     = IDLE;
          end else begin
            tmo_d = tmo_q + 13'd1;
          end
        end
      end

      FLUSH: begin
        bus.fft_source_ready = 1'b1;
        if (bus.fft_source_valid && bus.fft_source_eop) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.fft_sink_real  = bus.smp_data;
  assign bus.fft_sink_imag  = 24'd0;
  assign bus.fft_sink_error = 2'b00;
  assign bus.fft_fftpts_in  = 9'(PTS);
  assign bus.fft_inverse    = 1'b0;
  assign bus.bin_real       = bus.fft_source_real;
  assign bus.bin_imag       = bus.fft_source_imag;
  assign bus.bin_index      = out_cnt_q;
  assign bus.busy           = (state_q != IDLE);
  assign bus.frame_err      = frame_err_q;
  assign bus.frame_count    = frame_count_q;

endmodule
